// File: rtl/id_ex_pkg.sv
// Shared widths, NOP encodings and entry layout for the ID->EX skid register.
package id_ex_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ALUOP_W_DEF  = 8;
    localparam int ALUSEL_W_DEF = 3;
    localparam int NUM_SRC_DEF  = 2;

    // Bubble encodings, matching the core's defines.v
    localparam logic [ALUOP_W_DEF-1:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUSEL_W_DEF-1:0] EXE_RES_NOP  = 3'b000;
    localparam logic [DATA_W_DEF-1:0]   ZeroWord     = 32'h0000_0000;
    localparam logic                    WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [ALUOP_W_DEF-1:0]                 aluop;
        logic [ALUSEL_W_DEF-1:0]                alusel;
        logic [NUM_SRC_DEF-1:0][DATA_W_DEF-1:0] src;
        logic [ADDR_W_DEF-1:0]                  wd;
        logic                                   wreg;
    } entry_t;

    function automatic int entry_w(input int dw, input int aw, input int opw,
                                   input int selw, input int ns);
        return opw + selw + ns * dw + aw + 1;
    endfunction

endpackage

// File: rtl/id_ex_slot.sv
// One entry register of the ID->EX buffer: clear wins over load, otherwise hold.
module id_ex_slot
    import id_ex_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = CLR_VAL;
        end else if (load) begin
            data_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= CLR_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with a two-entry skid buffer and synchronous flush.
// Define ID_EX_PERF_EN to add the saturating perf_stall_cnt back-pressure counter.
module id_ex_skid
    import id_ex_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ALUOP_W  = ALUOP_W_DEF,
    parameter int ALUSEL_W = ALUSEL_W_DEF,
    parameter int NUM_SRC  = NUM_SRC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [ALUOP_W-1:0]        id_aluop,
    input  logic [ALUSEL_W-1:0]       id_alusel,
    input  logic [NUM_SRC*DATA_W-1:0] id_src,
    input  logic [ADDR_W-1:0]         id_wd,
    input  logic                      id_wreg,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [ALUOP_W-1:0]        ex_aluop,
    output logic [ALUSEL_W-1:0]       ex_alusel,
    output logic [NUM_SRC*DATA_W-1:0] ex_src,
    output logic [ADDR_W-1:0]         ex_wd,
    output logic                      ex_wreg
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam int ENTRY_W = entry_w(DATA_W, ADDR_W, ALUOP_W, ALUSEL_W, NUM_SRC);

    localparam logic [ENTRY_W-1:0] NOP_ENTRY = {
        ALUOP_W'(EXE_NOP_OP),
        ALUSEL_W'(EXE_RES_NOP),
        {NUM_SRC{DATA_W'(ZeroWord)}},
        ADDR_W'(0),
        WriteDisable
    };

    occ_e               state_q;
    occ_e               state_d;
    logic               push;
    logic               pop;
    logic               main_load;
    logic               main_clr;
    logic               main_from_skid;
    logic               skid_load;
    logic               skid_clr;
    logic [ENTRY_W-1:0] id_entry;
    logic [ENTRY_W-1:0] main_din;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;

    // Occupancy is the only control state; slot valids are decoded from it.
    assign id_ready = (state_q != FULL);
    assign ex_valid = (state_q != EMPTY);
    assign push     = id_valid & id_ready;
    assign pop      = ex_valid & ex_ready;

    assign id_entry = {id_aluop, id_alusel, id_src, id_wd, id_wreg};
    assign main_din = main_from_skid ? skid_q : id_entry;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (pop && push) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end else if (push) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    // id_ready is low here, so a pop can never coincide with a push
                    if (pop) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    id_ex_slot #(
        .W       (ENTRY_W),
        .CLR_VAL (NOP_ENTRY)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .clr  (main_clr),
        .din  (main_din),
        .dout (main_q)
    );

    id_ex_slot #(
        .W       (ENTRY_W),
        .CLR_VAL (NOP_ENTRY)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .clr  (skid_clr),
        .din  (id_entry),
        .dout (skid_q)
    );

    // The main slot is cleared whenever it empties, so its fields are the bubble.
    assign {ex_aluop, ex_alusel, ex_src, ex_wd, ex_wreg} = main_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_d;
    logic [31:0] perf_q;

    always_comb begin
        perf_d = perf_q;
        if (ex_valid && !ex_ready && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Scoreboarded random bench for id_ex_skid: the model is a bounded FIFO of depth 2.
module tb_id_ex_skid;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int OPW  = 8;
    localparam int SELW = 3;
    localparam int NS   = 2;
    localparam int EW   = OPW + SELW + NS * DW + AW + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              id_valid = 1'b0;
    logic              id_ready;
    logic [OPW-1:0]    id_aluop = '0;
    logic [SELW-1:0]   id_alusel = '0;
    logic [NS*DW-1:0]  id_src = '0;
    logic [AW-1:0]     id_wd = '0;
    logic              id_wreg = 1'b0;
    logic              ex_valid;
    logic              ex_ready = 1'b0;
    logic [OPW-1:0]    ex_aluop;
    logic [SELW-1:0]   ex_alusel;
    logic [NS*DW-1:0]  ex_src;
    logic [AW-1:0]     ex_wd;
    logic              ex_wreg;
`ifdef ID_EX_PERF_EN
    logic [31:0]       perf_stall_cnt;
`endif

    logic [EW-1:0]     ex_bus;
    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     pend = '0;
    bit                pend_v = 1'b0;
    bit                mon_en = 1'b0;
    int unsigned       stall_model = 0;
    int                total = 0;
    int                bad = 0;

    always #5 clk = ~clk;

    id_ex_skid #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .ALUOP_W  (OPW),
        .ALUSEL_W (SELW),
        .NUM_SRC  (NS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_aluop  (id_aluop),
        .id_alusel (id_alusel),
        .id_src    (id_src),
        .id_wd     (id_wd),
        .id_wreg   (id_wreg),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_aluop  (ex_aluop),
        .ex_alusel (ex_alusel),
        .ex_src    (ex_src),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg)
`ifdef ID_EX_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    assign ex_bus = {ex_aluop, ex_alusel, ex_src, ex_wd, ex_wreg};

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: the DUT must look exactly like a depth-2 FIFO holding exp_q.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("id_ready", EW'(id_ready), EW'(exp_q.size() < 2));
            chk("ex_valid", EW'(ex_valid), EW'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("ex_fields", ex_bus, exp_q[0]);
            else                   chk("nop_fields", ex_bus, '0);
`ifdef ID_EX_PERF_EN
            chk("perf_cnt", EW'(perf_stall_cnt), EW'(stall_model));
            if (exp_q.size() != 0 && !ex_ready) stall_model++;
`endif
            if (flush) exp_q.delete();
            else if (exp_q.size() != 0 && ex_ready) void'(exp_q.pop_front());
        end
    end

    // Driver: one call = one clock. pv/pr are percent chances of id_valid/ex_ready.
    task automatic cycle(input int pv, input int pr, input bit fl, input bit fixed);
        @(posedge clk);
        if (pend_v) exp_q.push_back(pend);
        pend_v = 1'b0;
        #1;
        // a stalled producer keeps its instruction until accepted (unless squashed)
        if (!(id_valid && exp_q.size() >= 2 && !flush)) begin
            id_valid = ($urandom_range(99) < pv);
            if (fixed) begin
                id_aluop  = 8'h25;
                id_alusel = 3'd1;
                id_src    = {32'h0000_5678, 32'h0000_1234};
                id_wd     = 5'd3;
                id_wreg   = 1'b1;
            end else begin
                id_aluop  = OPW'($urandom);
                id_alusel = SELW'($urandom);
                for (int k = 0; k < NS; k++) id_src[k*DW +: DW] = $urandom;
                id_wd     = AW'($urandom);
                id_wreg   = 1'($urandom);
            end
        end
        ex_ready = ($urandom_range(99) < pr);
        flush    = fl;
        if (id_valid && exp_q.size() < 2 && !fl) begin
            pend   = {id_aluop, id_alusel, id_src, id_wd, id_wreg};
            pend_v = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2;
        chk("rst_ex_valid", EW'(ex_valid), '0);
        chk("rst_id_ready", EW'(id_ready), EW'(1'b1));
        chk("rst_fields", ex_bus, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        mon_en = 1'b1;

        repeat (8) cycle(100, 100, 1'b0, 1'b1);
        repeat (300) cycle(70, 60, ($urandom_range(19) == 0), 1'b0);

        // back-pressure: A then B, hold, then drain in order
        repeat (3) cycle(0, 100, 1'b0, 1'b0);
        cycle(100, 0, 1'b0, 1'b0);
        cycle(100, 0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b0);
        repeat (3) cycle(0, 100, 1'b0, 1'b0);

        // flush while full with a competing push of C
        repeat (3) cycle(100, 0, 1'b0, 1'b0);
        cycle(100, 50, 1'b1, 1'b0);
        repeat (3) cycle(0, 100, 1'b0, 1'b0);

        // flush while holding one entry with a simultaneous push
        cycle(100, 0, 1'b0, 1'b0);
        cycle(100, 0, 1'b1, 1'b0);
        repeat (2) cycle(0, 100, 1'b0, 1'b0);

        // asynchronous reset while full, checked before the next edge
        repeat (3) cycle(100, 0, 1'b0, 1'b0);
        #2;
        mon_en   = 1'b0;
        rst      = 1'b0;
        id_valid = 1'b0;
        ex_ready = 1'b0;
        flush    = 1'b0;
        pend_v   = 1'b0;
        exp_q.delete();
        stall_model = 0;
        #1;
        chk("async_ex_valid", EW'(ex_valid), '0);
        chk("async_id_ready", EW'(id_ready), EW'(1'b1));
        chk("async_fields", ex_bus, '0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        mon_en = 1'b1;

`ifdef ID_EX_PERF_EN
        cycle(100, 0, 1'b0, 1'b0);
        repeat (7) cycle(0, 0, 1'b0, 1'b0);
        cycle(0, 100, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("perf_seven", EW'(perf_stall_cnt), EW'(32'd7));
`endif

        repeat (300) cycle(60, 50, ($urandom_range(29) == 0), 1'b0);
        repeat (4) cycle(0, 100, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
- Parametrised ID→EX pipeline register with a valid/ready handshake and a 2-entry skid buffer (main + skid slot).
- Carries ALU op/sel, NUM_SRC operand words, destination address and write-enable from decode to execute.
- Supports back-pressure from EX (multi-cycle ops) and a synchronous flush for branch/exception squash.
- Replaces the plain always-capture ID/EX register in the core pipeline.

Parameters:
- DATA_W, 32, operand word width
- ADDR_W, 5, register address width
- ALUOP_W, 8, aluop width
- ALUSEL_W, 3, alusel width
- NUM_SRC, 2, number of operand channels (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  squash all held entries
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  buffer can accept this cycle
- id_aluop  in  ALUOP_W
- id_alusel  in  ALUSEL_W
- id_src  in  NUM_SRC*DATA_W  operands; channel k at bits [k*DATA_W +: DATA_W]
- id_wd  in  ADDR_W  destination register
- id_wreg  in  1  destination write enable
- ex_valid  out  1  execute-side instruction valid
- ex_ready  in  1  execute consumes this cycle
- ex_aluop  out  ALUOP_W
- ex_alusel  out  ALUSEL_W
- ex_src  out  NUM_SRC*DATA_W
- ex_wd  out  ADDR_W
- ex_wreg  out  1
- perf_stall_cnt  out  32  present only with ID_EX_PERF_EN

Behaviour:
- Reset (rst=0, asynchronous): main_v=0, skid_v=0.
  - ex_aluop=EXE_NOP_OP, ex_alusel=EXE_RES_NOP, ex_src=0, ex_wd=0, ex_wreg=WriteDisable, ex_valid=0.
  - id_ready=1.
- id_ready = !skid_v. It is a registered flag with no combinational path from ex_ready.
- push = id_valid & id_ready; pop = ex_valid & ex_ready.
- ex_valid = main_v. ex_* fields come straight from the main-slot registers.
- Main slot empty: all ex_* fields hold the NOP values above. ex_wreg must never be 1 while ex_valid=0.
- Latency: a push into an empty buffer appears on ex_* on the next rising edge (1 cycle).
- Next-state rules, priority order:
  1. flush=1: main_v←0, skid_v←0, fields←NOP. Any same-cycle push is dropped and any pop is void.
  2. pop & skid_v: skid moves to main, skid_v←0. No push can occur because id_ready=0.
  3. pop & !skid_v & push: main←new entry, main_v stays 1.
  4. pop & !skid_v & !push: main_v←0, fields←NOP.
  5. !pop & push & !main_v: main←new entry.
  6. !pop & push & main_v: skid←new entry, skid_v←1, so id_ready=0 from the next cycle.
  7. Otherwise hold.
- Ordering is strictly FIFO. No entry is ever duplicated or lost, except by flush.
- Full (skid_v=1): id_valid is ignored and the ID stage must hold its inputs.
- Reset asserted mid-stall clears both slots immediately. There is no recovery of in-flight entries.

Optional Feature:
- Macro: ID_EX_PERF_EN
- Defined:
  - perf_stall_cnt counts cycles with ex_valid=1 & ex_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter logic are absent. No other behaviour changes.

Decomposition:
- Package id_ex_pkg holds:
  - default widths;
  - NOP constants (EXE_NOP_OP, EXE_RES_NOP, ZeroWord, WriteDisable), sourced from defines.v values;
  - a packed struct type for one slot entry (aluop, alusel, src array, wd, wreg).
- Sub-module id_ex_slot: one load/clear/hold entry register, instantiated twice (main, skid). Top level holds the control FSM (states EMPTY/ONE/FULL, derived from main_v/skid_v) and the optional counter.

Test Plan:
- Reset release, id_valid=0 → ex_valid=0, ex_aluop=EXE_NOP_OP, ex_wreg=0, id_ready=1.
- Streaming: push aluop=0x25, src={0x1234,0x5678}, wd=3, wreg=1 with ex_ready=1 every cycle → each entry appears exactly 1 cycle later; id_ready stays 1.
- Back-pressure: ex_ready=0; push A then B → id_ready drops after B. Raise ex_ready → A then B emerge in order, id_ready returns to 1.
- Flush while FULL with a simultaneous id_valid push of C → next cycle ex_valid=0, id_ready=1; C never appears.
- Async reset: assert rst=0 mid-cycle while FULL → outputs go to NOP before the next clock edge.
- ID_EX_PERF_EN: hold ex_valid=1, ex_ready=0 for 7 cycles → perf_stall_cnt=7. A flush leaves it at 7.
